spu_wb_stage: RTL and testbench
===============================

# spu_wb_stage

Writeback stage for the dual-issue SPU. It sits directly upstream of the 128x128 register file and drives the register file's even and odd write ports. Even-pipe and odd-pipe execution results arrive with differing latencies. Each result is placed in a per-pipe retire shift pipeline, so every write reaches the register file exactly `lat` cycles after it is presented. The stage also tells the issue logic which registers still have a write in flight.

## Interface
Parameters:
- `DEPTH`, 7, number of retire stages per pipe; the maximum legal latency.
- `ADDR_W`, 7, register address width.
- `DATA_W`, 128, register data width.

Ports:
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous, active-low (0 = reset).
- `flush`  in  1  discards all in-flight entries.
- `ex_v_e` / `ex_v_o`  in  1  even/odd result valid.
- `ex_addr_e` / `ex_addr_o`  in  ADDR_W  destination register (rt).
- `ex_data_e` / `ex_data_o`  in  DATA_W  result data.
- `ex_lat_e` / `ex_lat_o`  in  3  cycles until the register-file write; legal range is 1..DEPTH.
- `rt_we_e`, `rt_addr_e`, `rt_data_e`  out  1/ADDR_W/DATA_W  even write port to the register file.
- `rt_we_o`, `rt_addr_o`, `rt_data_o`  out  1/ADDR_W/DATA_W  odd write port to the register file.
- `q0_addr`, `q1_addr`  in  ADDR_W  pending-write query addresses.
- `q0_pend`, `q1_pend`  out  1  a matching write is in flight.
- `q0_fwd_v`, `q1_fwd_v`  out  1  forwarded data is valid.
- `q0_fwd_data`, `q1_fwd_data`  out  DATA_W  forwarded data.
- `err_lat`  out  1  pulse: an `ex_lat` value was out of range.
- `err_col`  out  1  pulse: slot collision on insert.
- `waw_drop`  out  1  pulse: a same-address even write was suppressed.

## Operation
Per-pipe state:
- Stage registers `st[1..DEPTH-1]`, each holding {valid, addr, data}; `st[k]` reaches the output register in k edges.
- An output register R that drives `rt_*` directly (the write ports are registered).

Each edge, per pipe:
- R <= `st[1]`, and `st[k]` <= `st[k+1]`; the top stage loads invalid.

Insertion when `ex_v` is high and `ex_lat` = L is legal:
- L=1 writes R directly; otherwise the entry is written into `st[L-1]`, overriding the shifted-in value.

Collision:
- If the shifted-in value at the target slot is valid, the shifted entry is kept and the new entry is dropped.
- `err_col` pulses for one cycle.

Illegal latency:
- L=0 or L>DEPTH drops the entry and pulses `err_lat`.

Simultaneous even/odd retire:
- If R_e and R_o are both valid with equal addr, the odd write wins.
- `rt_we_e` is forced to 0 and `waw_drop` pulses.
- The register file needs no ordering rule for this case.

Pending query (combinational):
- `qN_pend` = 1 if any valid `st[k]` in either pipe matches `qN_addr`.
- R is excluded, because the register file already bypasses its current write port.

Flush:
- Next edge, all `st` and R become invalid.
- Inserts in the flush cycle are ignored; error pulses are suppressed in that cycle.

Reset (`rst`=0):
- All valids, `rt_we_*`, `err_*` and `waw_drop` go to 0.
- `rt_addr_*`, `rt_data_*` and `qN_fwd_data` go to 0.

## Timing
- A result presented at edge E with L produces `rt_we`=1 in the cycle after edge E+L-1; the write lands on edge E+L.
- Throughput: one insert per pipe per cycle.
- Pending outputs update the cycle after insert; they are not combinational from `ex_*`.
- Reset mid-operation: all in-flight writes are lost, and no `rt_we` is asserted in the cycle after reset is released.
- The `err_col`, `err_lat` and `waw_drop` pulses each last exactly 1 cycle, registered.

## Configuration
- `SPU_WB_FWD_EN` defined: `qN_fwd_v`/`qN_fwd_data` return the matching entry that retires last (the largest k; odd pipe on a tie).
  - `qN_fwd_v` = `qN_pend`.
- `SPU_WB_FWD_EN` undefined: the forwarding data path is not built, and `qN_fwd_v`/`qN_fwd_data` are tied to 0.
  - Pending detection is unaffected.

## Test plan
- Even insert addr=5, data=0xA5..A5, L=3 at edge 0 -> `rt_we_e`=1, `rt_addr_e`=5 in the cycle after edge 2; `q0_addr`=5 gives `q0_pend`=1 in cycles 1-2 and 0 in cycle 3.
- Even L=4 at edge 0, then L=2 at edge 2 (same slot) -> first entry written, second dropped, `err_col`=1 one cycle.
- Even addr=9 L=2 and odd addr=9 L=2 at the same edge -> only `rt_we_o`=1 with odd data; `waw_drop`=1.
- `ex_lat_o`=0 and, separately, 7'... `ex_lat_o`=DEPTH+1 -> no write, `err_lat` pulses each time.
- Three entries in flight, `flush`=1 for one cycle -> no `rt_we` afterwards, all `qN_pend`=0; repeat with `rst`=0 mid-flight -> all outputs 0.
- `SPU_WB_FWD_EN`: addr=3 L=5 data=X1, then addr=3 L=5 data=X2 one cycle later -> `q1_fwd_data`=X2 while both are pending.

Source files
------------

// File: rtl/spu_wb_stage.sv
// spu_wb_stage
//
// Writeback stage for the dual-issue SPU, sitting directly in front of the register file.
// Even-pipe and odd-pipe results arrive with differing latencies. Each result is placed in a
// per-pipe retire shift pipeline, so the write reaches the register file exactly `lat` cycles
// after it is presented. The stage also reports which registers still have a write in flight.
//
// Per pipe there are stage registers st[1..DEPTH-1], where st[k] reaches the output register R
// in k edges. R drives the register-file write port directly, so the write ports are registered.
//
// Ports
//   clk, rst                    clock; synchronous active-low reset (0 = reset)
//   flush                       discard every in-flight entry on the next edge
//   ex_{v,addr,data,lat}_{e,o}  even/odd execution results; lat is legal in 1..DEPTH
//   rt_{we,addr,data}_{e,o}     even/odd register-file write ports
//   q{0,1}_addr                 pending-write query addresses
//   q{0,1}_pend                 a valid stage entry (R excluded) targets the queried register
//   q{0,1}_fwd_v, _fwd_data     forwarded data of the matching entry that retires last
//   err_lat                     1-cycle pulse: an ex_lat value was out of range
//   err_col                     1-cycle pulse: an insert hit an occupied slot and was dropped
//   waw_drop                    1-cycle pulse: even write suppressed by a same-address odd write
//
// Configuration
//   SPU_WB_FWD_EN  defined: build the forwarding mux (fwd_v = pend).
//                  undefined: q*_fwd_v and q*_fwd_data are tied to 0.

module spu_wb_stage #(
  parameter int unsigned DEPTH  = 7,
  parameter int unsigned ADDR_W = 7,
  parameter int unsigned DATA_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,

  input  logic              ex_v_e,
  input  logic [ADDR_W-1:0] ex_addr_e,
  input  logic [DATA_W-1:0] ex_data_e,
  input  logic [2:0]        ex_lat_e,
  input  logic              ex_v_o,
  input  logic [ADDR_W-1:0] ex_addr_o,
  input  logic [DATA_W-1:0] ex_data_o,
  input  logic [2:0]        ex_lat_o,

  output logic              rt_we_e,
  output logic [ADDR_W-1:0] rt_addr_e,
  output logic [DATA_W-1:0] rt_data_e,
  output logic              rt_we_o,
  output logic [ADDR_W-1:0] rt_addr_o,
  output logic [DATA_W-1:0] rt_data_o,

  input  logic [ADDR_W-1:0] q0_addr,
  input  logic [ADDR_W-1:0] q1_addr,
  output logic              q0_pend,
  output logic              q1_pend,
  output logic              q0_fwd_v,
  output logic              q1_fwd_v,
  output logic [DATA_W-1:0] q0_fwd_data,
  output logic [DATA_W-1:0] q1_fwd_data,

  output logic              err_lat,
  output logic              err_col,
  output logic              waw_drop
);

  // Index of the top stage; it always loads invalid.
  localparam int unsigned NS = DEPTH - 1;

  // Pipe 0 = even, pipe 1 = odd.
  logic [1:0]                    in_v;
  logic [1:0][ADDR_W-1:0]        in_addr;
  logic [1:0][DATA_W-1:0]        in_data;
  logic [1:0][2:0]               in_lat;
  logic [1:0][31:0]              lat_w;

  logic [1:0][NS:1]              st_v_q, st_v_d;
  logic [1:0][NS:1][ADDR_W-1:0]  st_a_q, st_a_d;
  logic [1:0][NS:1][DATA_W-1:0]  st_d_q, st_d_d;

  logic [1:0]                    r_v_q, r_v_d;
  logic [1:0][ADDR_W-1:0]        r_a_q, r_a_d;
  logic [1:0][DATA_W-1:0]        r_d_q, r_d_d;

  logic                          err_lat_q, err_lat_d;
  logic                          err_col_q, err_col_d;
  logic                          waw_q, waw_d;

  logic [1:0][ADDR_W-1:0]        q_addr;
  logic [1:0]                    q_pend;

  always_comb begin
    in_v    = {ex_v_o, ex_v_e};
    in_addr = {ex_addr_o, ex_addr_e};
    in_data = {ex_data_o, ex_data_e};
    in_lat  = {ex_lat_o, ex_lat_e};
    q_addr  = {q1_addr, q0_addr};
  end

  // Next state: shift, insert, flush, then even/odd same-address resolution on R.
  always_comb begin
    st_v_d    = '0;
    st_a_d    = '0;
    st_d_d    = '0;
    r_v_d     = '0;
    r_a_d     = '0;
    r_d_d     = '0;
    lat_w     = '0;
    err_lat_d = 1'b0;
    err_col_d = 1'b0;
    waw_d     = 1'b0;

    for (int unsigned p = 0; p < 2; p++) begin
      r_v_d[p] = st_v_q[p][1];
      r_a_d[p] = st_a_q[p][1];
      r_d_d[p] = st_d_q[p][1];
      for (int unsigned k = 1; k < NS; k++) begin
        st_v_d[p][k] = st_v_q[p][k+1];
        st_a_d[p][k] = st_a_q[p][k+1];
        st_d_d[p][k] = st_d_q[p][k+1];
      end

      lat_w[p] = 32'(in_lat[p]);
      if (in_v[p]) begin
        if (lat_w[p] == 0 || lat_w[p] > DEPTH) begin
          err_lat_d = 1'b1;
        end else if (lat_w[p] == 1) begin
          // The shifted-in entry already owns this slot; it wins.
          if (r_v_d[p]) begin
            err_col_d = 1'b1;
          end else begin
            r_v_d[p] = 1'b1;
            r_a_d[p] = in_addr[p];
            r_d_d[p] = in_data[p];
          end
        end else begin
          for (int unsigned k = 1; k <= NS; k++) begin
            if (lat_w[p] == k + 1) begin
              if (st_v_d[p][k]) begin
                err_col_d = 1'b1;
              end else begin
                st_v_d[p][k] = 1'b1;
                st_a_d[p][k] = in_addr[p];
                st_d_d[p][k] = in_data[p];
              end
            end
          end
        end
      end
    end

    if (flush) begin
      st_v_d    = '0;
      r_v_d     = '0;
      err_lat_d = 1'b0;
      err_col_d = 1'b0;
    end

    // Same register written by both ports in one cycle: the odd result is the newer one.
    if (r_v_d[0] && r_v_d[1] && (r_a_d[0] == r_a_d[1])) begin
      r_v_d[0] = 1'b0;
      waw_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_v_q    <= '0;
      st_a_q    <= '0;
      st_d_q    <= '0;
      r_v_q     <= '0;
      r_a_q     <= '0;
      r_d_q     <= '0;
      err_lat_q <= 1'b0;
      err_col_q <= 1'b0;
      waw_q     <= 1'b0;
    end else begin
      st_v_q    <= st_v_d;
      st_a_q    <= st_a_d;
      st_d_q    <= st_d_d;
      r_v_q     <= r_v_d;
      r_a_q     <= r_a_d;
      r_d_q     <= r_d_d;
      err_lat_q <= err_lat_d;
      err_col_q <= err_col_d;
      waw_q     <= waw_d;
    end
  end

  // Pending: stage entries only; R is already bypassed inside the register file.
  always_comb begin
    q_pend = '0;
    for (int unsigned q = 0; q < 2; q++) begin
      for (int unsigned p = 0; p < 2; p++) begin
        for (int unsigned k = 1; k <= NS; k++) begin
          if (st_v_q[p][k] && (st_a_q[p][k] == q_addr[q])) begin
            q_pend[q] = 1'b1;
          end
        end
      end
    end
  end

`ifdef SPU_WB_FWD_EN
  logic [1:0][DATA_W-1:0] fwd_data;

  // Scan in retire order so the last match is the youngest write: largest k, odd on a tie.
  always_comb begin
    fwd_data = '0;
    for (int unsigned q = 0; q < 2; q++) begin
      for (int unsigned k = 1; k <= NS; k++) begin
        for (int unsigned p = 0; p < 2; p++) begin
          if (st_v_q[p][k] && (st_a_q[p][k] == q_addr[q])) begin
            fwd_data[q] = st_d_q[p][k];
          end
        end
      end
    end
  end

  assign q0_fwd_v    = q_pend[0];
  assign q1_fwd_v    = q_pend[1];
  assign q0_fwd_data = fwd_data[0];
  assign q1_fwd_data = fwd_data[1];
`else
  assign q0_fwd_v    = 1'b0;
  assign q1_fwd_v    = 1'b0;
  assign q0_fwd_data = '0;
  assign q1_fwd_data = '0;
`endif

  assign q0_pend   = q_pend[0];
  assign q1_pend   = q_pend[1];

  assign rt_we_e   = r_v_q[0];
  assign rt_addr_e = r_a_q[0];
  assign rt_data_e = r_d_q[0];
  assign rt_we_o   = r_v_q[1];
  assign rt_addr_o = r_a_q[1];
  assign rt_data_o = r_d_q[1];

  assign err_lat   = err_lat_q;
  assign err_col   = err_col_q;
  assign waw_drop  = waw_q;

endmodule

// File: tb/tb_spu_wb_stage.sv
// Testbench for spu_wb_stage. Inputs are driven on the falling edge; a reference model tracks
// every in-flight write by the cycle in which it must appear on the write port, and pushes the
// expected outputs for each upcoming edge into a scoreboard queue. An independent monitor pops
// one record per cycle, shortly after the rising edge, and compares it with the DUT.

module tb_spu_wb_stage;

  localparam int unsigned DEPTH = 6;
  localparam int unsigned AW    = 7;
  localparam int unsigned DW    = 128;

  logic          clk = 1'b0;
  logic          rst, flush;
  logic          ex_v_e, ex_v_o;
  logic [AW-1:0] ex_addr_e, ex_addr_o;
  logic [DW-1:0] ex_data_e, ex_data_o;
  logic [2:0]    ex_lat_e, ex_lat_o;
  logic          rt_we_e, rt_we_o;
  logic [AW-1:0] rt_addr_e, rt_addr_o;
  logic [DW-1:0] rt_data_e, rt_data_o;
  logic [AW-1:0] q0_addr, q1_addr;
  logic          q0_pend, q1_pend, q0_fwd_v, q1_fwd_v;
  logic [DW-1:0] q0_fwd_data, q1_fwd_data;
  logic          err_lat, err_col, waw_drop;

  always #5 clk = ~clk;

  spu_wb_stage #(
    .DEPTH  (DEPTH),
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .ex_v_e      (ex_v_e),
    .ex_addr_e   (ex_addr_e),
    .ex_data_e   (ex_data_e),
    .ex_lat_e    (ex_lat_e),
    .ex_v_o      (ex_v_o),
    .ex_addr_o   (ex_addr_o),
    .ex_data_o   (ex_data_o),
    .ex_lat_o    (ex_lat_o),
    .rt_we_e     (rt_we_e),
    .rt_addr_e   (rt_addr_e),
    .rt_data_e   (rt_data_e),
    .rt_we_o     (rt_we_o),
    .rt_addr_o   (rt_addr_o),
    .rt_data_o   (rt_data_o),
    .q0_addr     (q0_addr),
    .q1_addr     (q1_addr),
    .q0_pend     (q0_pend),
    .q1_pend     (q1_pend),
    .q0_fwd_v    (q0_fwd_v),
    .q1_fwd_v    (q1_fwd_v),
    .q0_fwd_data (q0_fwd_data),
    .q1_fwd_data (q1_fwd_data),
    .err_lat     (err_lat),
    .err_col     (err_col),
    .waw_drop    (waw_drop)
  );

  // In-flight write: pipe, cycle index of the edge after which it shows on rt_*, addr, data.
  typedef struct {
    bit            p;
    int            w;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  typedef struct {
    bit            we_e, we_o;
    logic [AW-1:0] a_e, a_o;
    logic [DW-1:0] d_e, d_o;
    bit            pend0, pend1, fv0, fv1;
    logic [DW-1:0] fd0, fd1;
    bit            el, ec, waw;
    bit            zchk;
  } rec_t;

  ent_t fl[$];
  rec_t sb[$];
  int   m_edge = 0;
  int   checks = 0;
  int   errors = 0;
  int   mcyc   = 0;
  rec_t mr;

  function automatic logic [DW-1:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance the model across the next rising edge using the current stimulus values.
  task automatic model_edge();
    rec_t          r;
    ent_t          keep[$];
    ent_t          e;
    bit            v;
    int            lat, w, best;
    bit            hit;
    logic [AW-1:0] qa;
    logic [DW-1:0] bd;
    r = '{default: '0};
    if (!rst) begin
      fl.delete();
      r.zchk = 1'b1;
    end else if (flush) begin
      fl.delete();
    end else begin
      for (int p = 0; p < 2; p++) begin
        v   = (p == 1) ? ex_v_o : ex_v_e;
        lat = (p == 1) ? int'(ex_lat_o) : int'(ex_lat_e);
        if (v) begin
          if (lat == 0 || lat > int'(DEPTH)) begin
            r.el = 1'b1;
          end else begin
            w   = m_edge + lat - 1;
            hit = 1'b0;
            foreach (fl[i]) if (int'(fl[i].p) == p && fl[i].w == w) hit = 1'b1;
            if (hit) begin
              r.ec = 1'b1;
            end else begin
              e.p = (p == 1);
              e.w = w;
              e.a = (p == 1) ? ex_addr_o : ex_addr_e;
              e.d = (p == 1) ? ex_data_o : ex_data_e;
              fl.push_back(e);
            end
          end
        end
      end
    end
    foreach (fl[i]) begin
      if (fl[i].w == m_edge) begin
        if (fl[i].p) begin
          r.we_o = 1'b1; r.a_o = fl[i].a; r.d_o = fl[i].d;
        end else begin
          r.we_e = 1'b1; r.a_e = fl[i].a; r.d_e = fl[i].d;
        end
      end
    end
    if (r.we_e && r.we_o && r.a_e == r.a_o) begin
      r.we_e = 1'b0;
      r.waw  = 1'b1;
    end
    foreach (fl[i]) if (fl[i].w > m_edge) keep.push_back(fl[i]);
    fl = keep;
    for (int q = 0; q < 2; q++) begin
      qa   = (q == 1) ? q1_addr : q0_addr;
      hit  = 1'b0;
      best = -1;
      bd   = '0;
      foreach (fl[i]) begin
        if (fl[i].a == qa) begin
          hit = 1'b1;
          if (fl[i].w > best || (fl[i].w == best && fl[i].p)) begin
            best = fl[i].w;
            bd   = fl[i].d;
          end
        end
      end
      if (q == 1) r.pend1 = hit; else r.pend0 = hit;
`ifdef SPU_WB_FWD_EN
      if (q == 1) begin r.fv1 = hit; r.fd1 = bd; end
      else begin r.fv0 = hit; r.fd0 = bd; end
`endif
    end
    sb.push_back(r);
    m_edge++;
  endtask

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, mcyc, act, exp);
    end
  endfunction

  // Monitor: one scoreboard record per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow cycle %0d: got empty queue expected a record", mcyc);
      end else begin
        mr = sb.pop_front();
        chk("rt_we_e", DW'(rt_we_e), DW'(mr.we_e));
        chk("rt_we_o", DW'(rt_we_o), DW'(mr.we_o));
        if (mr.we_e) begin
          chk("rt_addr_e", DW'(rt_addr_e), DW'(mr.a_e));
          chk("rt_data_e", rt_data_e, mr.d_e);
        end
        if (mr.we_o) begin
          chk("rt_addr_o", DW'(rt_addr_o), DW'(mr.a_o));
          chk("rt_data_o", rt_data_o, mr.d_o);
        end
        if (mr.zchk) begin
          chk("rst_addr_e", DW'(rt_addr_e), '0);
          chk("rst_data_e", rt_data_e, '0);
          chk("rst_addr_o", DW'(rt_addr_o), '0);
          chk("rst_data_o", rt_data_o, '0);
        end
        chk("q0_pend", DW'(q0_pend), DW'(mr.pend0));
        chk("q1_pend", DW'(q1_pend), DW'(mr.pend1));
        chk("q0_fwd_v", DW'(q0_fwd_v), DW'(mr.fv0));
        chk("q1_fwd_v", DW'(q1_fwd_v), DW'(mr.fv1));
        chk("q0_fwd_data", q0_fwd_data, mr.fd0);
        chk("q1_fwd_data", q1_fwd_data, mr.fd1);
        chk("err_lat", DW'(err_lat), DW'(mr.el));
        chk("err_col", DW'(err_col), DW'(mr.ec));
        chk("waw_drop", DW'(waw_drop), DW'(mr.waw));
      end
      mcyc++;
    end
  end

  task automatic idle();
    ex_v_e    = 1'b0;
    ex_v_o    = 1'b0;
    ex_lat_e  = 3'd0;
    ex_lat_o  = 3'd0;
    ex_addr_e = '0;
    ex_addr_o = '0;
    ex_data_e = '0;
    ex_data_o = '0;
    flush     = 1'b0;
  endtask

  task automatic tick();
    model_edge();
    @(negedge clk);
    idle();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ins_e(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] l);
    ex_v_e = 1'b1; ex_addr_e = a; ex_data_e = d; ex_lat_e = l;
  endtask

  task automatic ins_o(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [2:0] l);
    ex_v_o = 1'b1; ex_addr_o = a; ex_data_o = d; ex_lat_o = l;
  endtask

  initial begin
    idle();
    rst     = 1'b0;
    q0_addr = '0;
    q1_addr = '0;
    ticks(3);
    rst = 1'b1;
    tick();

    // Basic latency and pending window.
    q0_addr = 7'd5;
    ins_e(7'd5, {16{8'hA5}}, 3'd3);
    tick();
    ticks(4);

    // Slot collision: the older entry keeps the slot.
    q0_addr = 7'd20;
    ins_e(7'd20, rnd128(), 3'd4);
    tick();
    tick();
    ins_e(7'd21, rnd128(), 3'd2);
    tick();
    ticks(5);

    // Same-address retire on both ports.
    ins_e(7'd9, rnd128(), 3'd2);
    ins_o(7'd9, rnd128(), 3'd2);
    tick();
    ticks(3);

    // Out-of-range latencies.
    ins_o(7'd1, rnd128(), 3'd0);
    tick();
    tick();
    ins_o(7'd1, rnd128(), 3'(DEPTH + 1));
    tick();
    ticks(2);

    // Flush with three entries in flight.
    q0_addr = 7'd11;
    q1_addr = 7'd12;
    ins_e(7'd11, rnd128(), 3'd5);
    ins_o(7'd12, rnd128(), 3'd4);
    tick();
    ins_e(7'd13, rnd128(), 3'd5);
    tick();
    flush = 1'b1;
    tick();
    ticks(6);

    // Reset with three entries in flight.
    ins_e(7'd11, rnd128(), 3'd5);
    ins_o(7'd12, rnd128(), 3'd4);
    tick();
    ins_e(7'd13, rnd128(), 3'd5);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    ticks(6);

    // Youngest same-address write is the forwarding source.
    q1_addr = 7'd3;
    ins_e(7'd3, {4{32'h1111_0001}}, 3'd5);
    tick();
    ins_e(7'd3, {4{32'h2222_0002}}, 3'd5);
    tick();
    ticks(6);

    // Randomized traffic over a small address set to provoke collisions and WAW.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 2) != 0) ins_e(7'($urandom_range(0, 7)), rnd128(),
                                           3'($urandom_range(0, 7)));
      if ($urandom_range(0, 2) != 0) ins_o(7'($urandom_range(0, 7)), rnd128(),
                                           3'($urandom_range(0, 7)));
      q0_addr = 7'($urandom_range(0, 7));
      q1_addr = 7'($urandom_range(0, 7));
      if ($urandom_range(0, 59) == 0) flush = 1'b1;
      if (!rst) begin
        rst = 1'b1;
        idle();
      end else if ($urandom_range(0, 299) == 0) begin
        rst = 1'b0;
      end
      tick();
    end

    ticks(8);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
